interrupt_controller: RTL and testbench

- Sits directly upstream of the processor top level and drives its single `interrupt` input.
- Synchronizes several asynchronous external request lines, edge-detects them and latches them as pending.
- Picks one request by fixed priority and asserts `interrupt` for a programmable number of cycles.
- Then holds off further requests until the processor reports return-from-interrupt (`rti_done`).

---
 rtl/interrupt_controller_pkg.sv | 29 ++
 rtl/interrupt_controller_sync_edge.sv | 44 ++++
 rtl/interrupt_controller.sv | 175 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// ============================================================================
// Module      : interrupt_controller_pkg
// Description : Shared state encoding, default sizes and width helper for
//               the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam int DEF_NUM_SRC        = 4;
    localparam int DEF_PULSE_CYCLES   = 2;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_sync_edge.sv
// ============================================================================
// Module      : irq_sync_edge
// Description : Multi-flop synchronizer for one asynchronous request line
//               followed by a single-cycle rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sync_edge
    import interrupt_controller_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic req_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Synchronizes and latches external requests, selects one by
//               fixed priority, pulses `interrupt` and waits for rti_done.
//               Optional service watchdog: INTERRUPT_CONTROLLER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter  int NUM_SRC        = DEF_NUM_SRC,
    parameter  int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter  int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int SRC_W          = clog2_min1(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               hold_off,
    input  logic               rti_done,
    output logic               interrupt,
    output logic [SRC_W-1:0]   int_src,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic               timeout_err
);

    localparam int CNT_W = clog2_min1(PULSE_CYCLES);

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [SRC_W-1:0]   sel;
    logic               any_eligible;

    irq_state_e         state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [SRC_W-1:0]   int_src_q,   int_src_d;
    logic               interrupt_q, interrupt_d;
    logic               busy_q,      busy_d;
    logic [NUM_SRC-1:0] pending_q,   pending_d;

`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
    localparam int WD_W = clog2_min1(TIMEOUT_CYCLES);

    logic [WD_W-1:0]    wd_q,        wd_d;
    logic               terr_q,      terr_d;
`endif

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk       (clk),
            .reset     (reset),
            .req_async (irq_req[g]),
            .rise      (rise[g])
        );
    end

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        eligible     = pending_q & ~irq_mask;
        sel          = '0;
        any_eligible = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel          = SRC_W'(i);
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        int_src_d   = int_src_q;
        interrupt_d = interrupt_q;
        clr         = '0;
`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
        wd_d        = wd_q;
        terr_d      = terr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_eligible && !hold_off) begin
                    state_d     = ST_ASSERT;
                    int_src_d   = sel;
                    clr         = NUM_SRC'(1) << sel;
                    cnt_d       = CNT_W'(PULSE_CYCLES - 1);
                    interrupt_d = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_SERVICE;
                    interrupt_d = 1'b0;
`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
                    wd_d        = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SERVICE: begin
                // A return in the same cycle as the timeout is a clean return.
                if (rti_done) begin
                    state_d = ST_IDLE;
                end
`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d     = ST_IDLE;
                interrupt_d = 1'b0;
            end
        endcase

        // A new edge on the bit being cleared must not be lost.
        pending_d = (pending_q & ~clr) | rise;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            int_src_q   <= '0;
            interrupt_q <= 1'b0;
            busy_q      <= 1'b0;
            pending_q   <= '0;
`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
            wd_q        <= '0;
            terr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            int_src_q   <= int_src_d;
            interrupt_q <= interrupt_d;
            busy_q      <= busy_d;
            pending_q   <= pending_d;
`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
            wd_q        <= wd_d;
            terr_q      <= terr_d;
`endif
        end
    end

    assign interrupt = interrupt_q;
    assign int_src   = int_src_q;
    assign busy      = busy_q;
    assign pending   = pending_q;

`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed and random checks of interrupt_controller against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    localparam int NUM_SRC = 4;
    localparam int PULSE   = 2;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq_req;
    logic [NUM_SRC-1:0] irq_mask;
    logic               hold_off;
    logic               rti_done;
    logic               interrupt;
    logic [1:0]         int_src;
    logic               busy;
    logic [NUM_SRC-1:0] pending;
    logic               timeout_err;

    int checks = 0;
    int errors = 0;

    interrupt_controller #(
        .NUM_SRC        (NUM_SRC),
        .PULSE_CYCLES   (PULSE),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .irq_req     (irq_req),
        .irq_mask    (irq_mask),
        .hold_off    (hold_off),
        .rti_done    (rti_done),
        .interrupt   (interrupt),
        .int_src     (int_src),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = pulsing, 2 = awaiting return.
    logic [NUM_SRC-1:0] past [0:SYNC+1];
    logic [NUM_SRC-1:0] m_pend;
    int                 m_phase, m_left, m_svc, m_src;
    logic               m_err;

    task automatic model_reset();
        for (int k = 0; k <= SYNC + 1; k++) past[k] = '0;
        m_pend  = '0;
        m_phase = 0;
        m_left  = 0;
        m_svc   = 0;
        m_src   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        logic [NUM_SRC-1:0] rise_v;
        logic [NUM_SRC-1:0] clr_v;
        bit                 found;
        for (int k = SYNC + 1; k >= 1; k--) past[k] = past[k-1];
        past[0] = irq_req;
        rise_v  = past[SYNC] & ~past[SYNC+1];
        clr_v   = '0;
        found   = 1'b0;
        case (m_phase)
            0: if (!hold_off) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (!found && m_pend[i] && !irq_mask[i]) begin
                        found    = 1'b1;
                        m_src    = i;
                        clr_v[i] = 1'b1;
                        m_phase  = 1;
                        m_left   = PULSE;
                    end
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_svc   = 0;
                end
            end
            default: begin
                m_svc++;
                if (rti_done) m_phase = 0;
`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
                else if (m_svc == TIMEOUT) begin
                    m_phase = 0;
                    m_err   = 1'b1;
                end
`endif
            end
        endcase
        m_pend = (m_pend & ~clr_v) | rise_v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("interrupt", 32'(interrupt), 32'(m_phase == 1));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("int_src", 32'(int_src), 32'(m_src));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_req  = '0;
        irq_mask = '0;
        hold_off = 1'b0;
        rti_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Idle after reset with no requests.
        steps(20);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_pending", 32'(pending), 32'd0);

        // Single request on source 2.
        irq_req[2] = 1'b1;
        steps(3);
        chk("pend2_latency", 32'(pending[2]), 32'd1);
        step();
        chk("src2_int", 32'(interrupt), 32'd1);
        chk("src2_id", 32'(int_src), 32'd2);
        step();
        chk("src2_pulse2", 32'(interrupt), 32'd1);
        step();
        chk("src2_pulse_end", 32'(interrupt), 32'd0);
        chk("src2_service", 32'(busy), 32'd1);
        irq_req[2] = 1'b0;
        steps(3);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
        chk("src2_rti", 32'(busy), 32'd0);
        steps(2);

        // Simultaneous requests on 3 and 1: 1 first, then 3.
        irq_req = 4'b1010;
        steps(4);
        chk("pri_first", 32'(int_src), 32'd1);
        steps(3);
        irq_req  = '0;
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
        step();
        chk("pri_second_int", 32'(interrupt), 32'd1);
        chk("pri_second_id", 32'(int_src), 32'd3);
        steps(3);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
        steps(2);

        // hold_off blocks acceptance while pending.
        hold_off   = 1'b1;
        irq_req[0] = 1'b1;
        steps(3);
        chk("hold_pend", 32'(pending[0]), 32'd1);
        steps(5);
        chk("hold_noint", 32'(interrupt), 32'd0);
        hold_off = 1'b0;
        step();
        chk("hold_release", 32'(interrupt), 32'd1);
        irq_req[0] = 1'b0;
        steps(3);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
        steps(2);

        // Masked source stays pending until unmasked.
        irq_mask[0] = 1'b1;
        irq_req[0]  = 1'b1;
        steps(7);
        chk("mask_pend", 32'(pending[0]), 32'd1);
        chk("mask_noint", 32'(interrupt), 32'd0);
        irq_mask[0] = 1'b0;
        step();
        chk("unmask_int", 32'(interrupt), 32'd1);
        chk("unmask_id", 32'(int_src), 32'd0);
        irq_req[0] = 1'b0;
        steps(3);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
        steps(2);

        // Watchdog: no return from the handler.
        irq_req[3] = 1'b1;
        steps(4 + PULSE + TIMEOUT + 1);
        irq_req[3] = 1'b0;
`ifdef INTERRUPT_CONTROLLER_TIMEOUT_EN
        chk("wd_err", 32'(timeout_err), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
`else
        chk("no_wd_err", 32'(timeout_err), 32'd0);
        chk("no_wd_busy", 32'(busy), 32'd1);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
`endif
        steps(2);

        // Asynchronous reset in the middle of the pulse.
        irq_req[1] = 1'b1;
        steps(4);
        chk("pre_reset_int", 32'(interrupt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_int", 32'(interrupt), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        irq_req = '0;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        steps(2);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < NUM_SRC; b++)
                if ($urandom_range(0, 9) < 3) irq_req[b] = ~irq_req[b];
            if ($urandom_range(0, 9) == 0) irq_mask = NUM_SRC'($urandom_range(0, 15) & $urandom_range(0, 15));
            hold_off = ($urandom_range(0, 4) == 0);
            rti_done = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
